// File: rtl/arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states,
// data-access size codes and the last-grant identities.
package arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_D  = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    // d_size / mem_size encodings
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Identity of the requester served last
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selector for the memory-port arbiter.
// Ports: if_req/d_req requests in, last_d = data was served last,
// grant_if/grant_d one-hot (or zero) grant out.
// RR = 0: data always beats fetch on a tie.
// RR = 1: on a tie the requester not served last wins.
module arb_pick
    import arb_pkg::*;
#(
    parameter bit RR = 1'b0
) (
    input  logic if_req,
    input  logic d_req,
    input  logic last_d,
    output logic grant_if,
    output logic grant_d
);

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (d_req && if_req) begin
            if (RR && (last_d == GRANT_D)) begin
                grant_if = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_if = if_req;
            grant_d  = d_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data
// access. Requests are sampled only in IDLE; the winner's command is
// registered onto mem_* and held until mem_ack, then the winner gets
// its read data and a one-cycle done pulse in RESP.
// Ports: clk, rst (sync, active-high); fetch side if_req/if_addr ->
// if_rdata/if_done/if_stall; data side d_req/d_we/d_size/d_addr/
// d_wdata -> d_rdata/d_done/d_stall; memory side mem_req/mem_we/
// mem_size/mem_addr/mem_wdata, mem_rdata/mem_ack.
// Build option: define ARB_ROUND_ROBIN_EN for alternating tie-break;
// otherwise data has fixed priority over fetch.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t state;
    logic       grant_if;
    logic       grant_d;
    logic       last_d;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
    logic last_grant;
    assign last_d = last_grant;
`else
    localparam bit RR_EN = 1'b0;
    assign last_d = GRANT_IF;
`endif

    arb_pick #(
        .RR(RR_EN)
    ) u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
        .last_d  (last_d),
        .grant_if(grant_if),
        .grant_d (grant_d)
    );

    // Stall drops in the done cycle so the pipeline advances there
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_size   <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= GRANT_IF;
`endif
        end else begin
            // done is a single-cycle pulse
            if_done <= 1'b0;
            d_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= SERVE_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_size  <= d_size;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= GRANT_D;
`endif
                    end else if (grant_if) begin
                        state     <= SERVE_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_size  <= SIZE_WORD;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= GRANT_IF;
`endif
                    end
                end
                SERVE_IF: begin
                    if (mem_ack) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                    end
                end
                SERVE_D: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        d_done  <= 1'b1;
                        // stores keep the last load value
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized transactions against a behavioural reference model.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit          m_last_d;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_size   (d_size),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .d_stall  (d_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_size (mem_size),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last_d = 1'b0;
        m_if_rdata = '0;
        m_d_rdata = '0;
    endtask

    // Memory responder: waits for mem_req, acks after lat cycles,
    // reports the command seen and the done pulses observed.
    task automatic run_txn(
        input  int          lat,
        input  logic [31:0] rd,
        output logic [31:0] a,
        output logic        w,
        output logic [1:0]  s,
        output logic [31:0] wd,
        output bit          stable,
        output int          nif,
        output int          nd,
        output int          wc,
        output bit          to,
        output bit          sok
    );
        stable = 1'b1;
        nif = 0;
        nd = 0;
        wc = 0;
        to = 1'b0;
        sok = 1'b1;
        a = '0;
        w = 1'b0;
        s = '0;
        wd = '0;
        while (mem_req !== 1'b1 && wc < 20) begin
            @(negedge clk);
            wc++;
            nif += int'(if_done);
            nd += int'(d_done);
        end
        if (mem_req !== 1'b1) begin
            to = 1'b1;
            return;
        end
        a = mem_addr;
        w = mem_we;
        s = mem_size;
        wd = mem_wdata;
        for (int k = 1; k <= lat; k++) begin
            if (mem_req !== 1'b1 || mem_addr !== a || mem_we !== w ||
                mem_size !== s || mem_wdata !== wd)
                stable = 1'b0;
            if (if_stall !== (if_req & ~if_done)) sok = 1'b0;
            if (d_stall !== (d_req & ~d_done)) sok = 1'b0;
            if (k == lat) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        nif += int'(if_done);
        nd += int'(d_done);
        if (mem_req !== 1'b0) stable = 1'b0;
        if (if_stall !== (if_req & ~if_done)) sok = 1'b0;
        if (d_stall !== (d_req & ~d_done)) sok = 1'b0;
        @(negedge clk);
        nif += int'(if_done);
        nd += int'(d_done);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_size !== 2'b00) begin
            failures++;
            $display("FAIL reset_mem_ctl got req=%b we=%b size=%b want 0 0 00",
                     mem_req, mem_we, mem_size);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem_data got addr=%h wdata=%h want 0 0",
                     mem_addr, mem_wdata);
        end
        checks++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got if=%h d=%h want 0 0",
                     if_rdata, d_rdata);
        end
        checks++;
        if (if_done !== 1'b0 || d_done !== 1'b0 ||
            if_stall !== 1'b0 || d_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got %b%b%b%b want 0000",
                     if_done, d_done, if_stall, d_stall);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] a, wd;
        logic w;
        logic [1:0] s;
        bit st, to, sok;
        int nif, nd, wc;
        if_addr = 32'h10;
        if_req = 1'b1;
        d_req = 1'b0;
        run_txn(1, 32'h0050_0093, a, w, s, wd, st, nif, nd, wc, to, sok);
        if_req = 1'b0;
        m_if_rdata = 32'h0050_0093;
        m_last_d = 1'b0;
        checks++;
        if (to || wc != 1) begin
            failures++;
            $display("FAIL fetch_latency got wait=%0d to=%0b want 1 0", wc, to);
        end
        checks++;
        if (a !== 32'h10 || w !== 1'b0 || s !== SIZE_WORD) begin
            failures++;
            $display("FAIL fetch_cmd got addr=%h we=%b size=%b want 10 0 10",
                     a, w, s);
        end
        checks++;
        if (nif != 1 || nd != 0) begin
            failures++;
            $display("FAIL fetch_done got if=%0d d=%0d want 1 0", nif, nd);
        end
        checks++;
        if (if_rdata !== m_if_rdata) begin
            failures++;
            $display("FAIL fetch_rdata got %h want %h", if_rdata, m_if_rdata);
        end
        checks++;
        if (!sok) begin
            failures++;
            $display("FAIL fetch_stall got bad want if_req&~if_done");
        end
    endtask

    task automatic test_priority();
        logic [31:0] a, wd;
        logic w;
        logic [1:0] s;
        bit st, to, sok;
        int nif, nd, wc;
        if_addr = 32'h20;
        d_we = 1'b1;
        d_addr = 32'h40;
        d_wdata = 32'hDEAD_BEEF;
        d_size = SIZE_WORD;
        if_req = 1'b1;
        d_req = 1'b1;
        run_txn(1, 32'hAAAA_5555, a, w, s, wd, st, nif, nd, wc, to, sok);
        d_req = 1'b0;
        m_last_d = 1'b1;
        checks++;
        if (to || a !== 32'h40 || w !== 1'b1 || s !== SIZE_WORD ||
            wd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL prio_first got addr=%h we=%b size=%b wd=%h want 40 1 10 deadbeef",
                     a, w, s, wd);
        end
        checks++;
        if (nd != 1 || nif != 0 || d_rdata !== m_d_rdata) begin
            failures++;
            $display("FAIL prio_store got d=%0d if=%0d drd=%h want 1 0 %h",
                     nd, nif, d_rdata, m_d_rdata);
        end
        run_txn(2, 32'h1357_9BDF, a, w, s, wd, st, nif, nd, wc, to, sok);
        if_req = 1'b0;
        m_if_rdata = 32'h1357_9BDF;
        m_last_d = 1'b0;
        checks++;
        if (to || wc != 1 || a !== 32'h20 || w !== 1'b0 || nif != 1 ||
            nd != 0 || if_rdata !== m_if_rdata) begin
            failures++;
            $display("FAIL prio_fetch got wc=%0d addr=%h if=%0d rd=%h want 1 20 1 %h",
                     wc, a, nif, if_rdata, m_if_rdata);
        end
    endtask

    task automatic test_order();
        logic [31:0] a, wd, rd;
        logic w;
        logic [1:0] s;
        bit st, to, sok;
        int nif, nd, wc;
        bit exp_d;
        do_reset();
        if_addr = 32'h100;
        d_addr = 32'h200;
        d_we = 1'b0;
        d_size = SIZE_HALF;
        if_req = 1'b1;
        d_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd = $urandom;
            run_txn(1, rd, a, w, s, wd, st, nif, nd, wc, to, sok);
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (i % 2) == 0;
`else
            exp_d = 1'b1;
`endif
            checks++;
            if (to || nd != int'(exp_d) || nif != int'(!exp_d)) begin
                failures++;
                $display("FAIL order_%0d got d=%0d if=%0d want d=%0d",
                         i, nd, nif, exp_d);
            end
            m_last_d = exp_d;
            if (exp_d) m_d_rdata = rd;
            else m_if_rdata = rd;
        end
        if_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (d_rdata !== m_d_rdata || if_rdata !== m_if_rdata) begin
            failures++;
            $display("FAIL order_rdata got d=%h if=%h want %h %h",
                     d_rdata, if_rdata, m_d_rdata, m_if_rdata);
        end
    endtask

    task automatic test_long_ack();
        logic [31:0] a, wd;
        logic w;
        logic [1:0] s;
        bit st, to, sok;
        int nif, nd, wc;
        d_we = 1'b1;
        d_addr = 32'h300;
        d_wdata = 32'hCAFE_F00D;
        d_size = SIZE_BYTE;
        d_req = 1'b1;
        if_req = 1'b0;
        run_txn(5, 32'h7777_7777, a, w, s, wd, st, nif, nd, wc, to, sok);
        d_req = 1'b0;
        m_last_d = 1'b1;
        checks++;
        if (to || !st || a !== 32'h300 || wd !== 32'hCAFE_F00D ||
            s !== SIZE_BYTE) begin
            failures++;
            $display("FAIL long_stable got st=%0b addr=%h wd=%h size=%b want 1 300 cafef00d 00",
                     st, a, wd, s);
        end
        checks++;
        if (nd != 1 || nif != 0 || d_rdata !== m_d_rdata || !sok) begin
            failures++;
            $display("FAIL long_done got d=%0d if=%0d rd=%h sok=%0b want 1 0 %h 1",
                     nd, nif, d_rdata, sok, m_d_rdata);
        end
    endtask

    task automatic test_drop();
        int seen;
        d_we = 1'b0;
        d_addr = 32'h80;
        d_size = SIZE_WORD;
        d_req = 1'b1;
        seen = 0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            failures++;
            $display("FAIL drop_grant got req=%b addr=%h want 1 80",
                     mem_req, mem_addr);
        end
        d_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        seen += int'(d_done);
        m_d_rdata = 32'h1234_5678;
        m_last_d = 1'b1;
        checks++;
        if (d_done !== 1'b1 || d_rdata !== m_d_rdata || d_stall !== 1'b0) begin
            failures++;
            $display("FAIL drop_done got done=%b rd=%h stall=%b want 1 %h 0",
                     d_done, d_rdata, d_stall, m_d_rdata);
        end
        @(negedge clk);
        seen += int'(d_done);
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL drop_pulse got %0d want 1", seen);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] a, wd;
        logic w;
        logic [1:0] s;
        bit st, to, sok;
        int nif, nd, wc;
        int seen;
        d_we = 1'b0;
        d_addr = 32'h90;
        d_req = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_serve got req=%b want 1", mem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_last_d = 1'b0;
        m_if_rdata = '0;
        m_d_rdata = '0;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_size !== 2'b00 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            d_rdata !== 32'h0 || if_rdata !== 32'h0 ||
            d_done !== 1'b0 || if_done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear got req=%b addr=%h drd=%h ifrd=%h want all 0",
                     mem_req, mem_addr, d_rdata, if_rdata);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        seen = 0;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen += int'(d_done) + int'(if_done) + int'(mem_req);
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_stale got activity=%0d rd=%h want 0 0",
                     seen, d_rdata);
        end
        if_addr = 32'h44;
        if_req = 1'b1;
        run_txn(1, 32'h0000_0013, a, w, s, wd, st, nif, nd, wc, to, sok);
        if_req = 1'b0;
        m_if_rdata = 32'h0000_0013;
        checks++;
        if (to || wc != 1 || nif != 1 || nd != 0 || if_rdata !== m_if_rdata) begin
            failures++;
            $display("FAIL rstmid_idle got wc=%0d if=%0d d=%0d rd=%h want 1 1 0 %h",
                     wc, nif, nd, if_rdata, m_if_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd;
        logic w;
        logic [1:0] s;
        bit st, to, sok;
        int nif, nd, wc, lat;
        bit exp_d;
        logic [31:0] e_a, e_wd;
        logic e_w;
        logic [1:0] e_s;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if_req = 1'($urandom);
            d_req = 1'($urandom);
            if (!if_req && !d_req) if_req = 1'b1;
            if_addr = $urandom;
            d_addr = $urandom;
            d_we = 1'($urandom);
            d_size = 2'($urandom_range(0, 2));
            d_wdata = $urandom;
            rd = $urandom;
            lat = $urandom_range(1, 4);
            // data wins unless both ask and data went last (RR only)
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = d_req && !(if_req && m_last_d);
`else
            exp_d = d_req;
`endif
            e_a = exp_d ? d_addr : if_addr;
            e_w = exp_d ? d_we : 1'b0;
            e_s = exp_d ? d_size : SIZE_WORD;
            e_wd = exp_d ? d_wdata : 32'h0;
            run_txn(lat, rd, a, w, s, wd, st, nif, nd, wc, to, sok);
            if_req = 1'b0;
            d_req = 1'b0;
            m_last_d = exp_d;
            if (exp_d && !e_w) m_d_rdata = rd;
            if (!exp_d) m_if_rdata = rd;
            checks++;
            if (to || !st || !sok) begin
                failures++;
                $display("FAIL rnd%0d_proto got to=%0b st=%0b sok=%0b want 0 1 1",
                         i, to, st, sok);
            end
            checks++;
            if (nd != int'(exp_d) || nif != int'(!exp_d)) begin
                failures++;
                $display("FAIL rnd%0d_grant got d=%0d if=%0d want d=%0d",
                         i, nd, nif, exp_d);
            end
            checks++;
            if (a !== e_a || w !== e_w || s !== e_s || wd !== e_wd) begin
                failures++;
                $display("FAIL rnd%0d_cmd got %h %b %b %h want %h %b %b %h",
                         i, a, w, s, wd, e_a, e_w, e_s, e_wd);
            end
            checks++;
            if (if_rdata !== m_if_rdata || d_rdata !== m_d_rdata) begin
                failures++;
                $display("FAIL rnd%0d_rdata got if=%h d=%h want %h %h",
                         i, if_rdata, d_rdata, m_if_rdata, m_d_rdata);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_size = 2'b00;
        d_addr = '0;
        d_wdata = '0;
        mem_rdata = '0;
        mem_ack = 1'b0;
        test_reset();
        test_fetch();
        test_priority();
        test_order();
        test_long_ack();
        test_drop();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width.
REQ-002 SHALL have parameter: DATA_W, 32, data width.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: if_req  input  1  fetch request (read-only); if_addr  input  ADDR_W  fetch address.
REQ-006 SHALL have ports: if_rdata  output  DATA_W  fetched word; if_done  output  1  one-cycle completion pulse; if_stall  output  1  hold PC and IF/ID.
REQ-007 SHALL have ports: d_req  input  1  data request; d_we  input  1  1 = store; d_size  input  2  00 = byte, 01 = half, 10 = word; d_addr  input  ADDR_W; d_wdata  input  DATA_W.
REQ-008 SHALL have ports: d_rdata  output  DATA_W  load data; d_done  output  1  completion pulse; d_stall  output  1  freeze pipeline up to EX/MEM.
REQ-009 SHALL have ports: mem_req  output  1; mem_we  output  1; mem_size  output  2; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W; mem_ack  input  1  memory completion; latency is one or more cycles.

Function
REQ-010 SHALL implement FSM states IDLE, SERVE_IF, SERVE_D, RESP.
REQ-011 SHALL sample requests only in IDLE; requests in SERVE_* or RESP are held pending and are not acted on.
REQ-012 SHALL, in IDLE with any request, register the winner's addr/we/size/wdata into mem_* at the edge and enter SERVE_IF or SERVE_D; mem_we is forced 0 for a fetch.
REQ-013 SHALL drive mem_req = 1 exactly while in SERVE_*; mem_* remain stable until mem_ack.
REQ-014 SHALL, on mem_ack in SERVE_*, capture mem_rdata into the winner's rdata register (stores leave d_rdata unchanged), enter RESP, and pulse the winner's done for that one RESP cycle.
REQ-015 SHALL return from RESP to IDLE unconditionally; minimum request-to-done latency is 2 edges, minimum turnaround is 3 cycles per access.
REQ-016 SHALL, when arbitration is fixed-priority, grant d_req over if_req when both are high in IDLE.
REQ-017 SHALL drive if_stall = if_req & ~if_done and d_stall = d_req & ~d_done.
REQ-018 SHALL complete a granted transaction even if its req drops mid-SERVE; done still pulses.
REQ-019 SHALL ignore mem_ack in IDLE and RESP.
REQ-020 SHALL pass d_size unchanged to mem_size; alignment is not checked.

Reset
REQ-021 SHALL, on rst, enter IDLE and clear mem_req, mem_we, mem_size, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done, and the last-grant bit to 0 at the same edge.
REQ-022 SHALL abandon any in-flight transaction on reset; a subsequent stale mem_ack produces no done.

Configuration
REQ-023 SHALL, with ARB_ROUND_ROBIN_EN defined, grant the requester not served last when both request in IDLE; the last-grant bit resets to IF, so data wins the first tie.
REQ-024 SHALL, without ARB_ROUND_ROBIN_EN, use fixed data-over-fetch priority; the last-grant bit is then absent.

Structure
REQ-025 SHALL take state encodings and d_size encodings (byte/half/word) from the shared package arb_pkg, alongside the existing defines.
REQ-026 SHALL contain one sub-module, arb_pick: a combinational grant selector covering fixed and round-robin modes.

Verification
REQ-027 SHALL cover: if_req=1, if_addr=0x10, mem_ack 1 cycle after mem_req, mem_rdata=0x00500093 -> if_done pulses 2 edges after request; if_rdata=0x00500093; if_stall high until then.
REQ-028 SHALL cover: if_req and d_req high together, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_size=10 -> first mem_req has mem_we=1, mem_addr=0x40; fetch is served after RESP.
REQ-029 SHALL cover, with ARB_ROUND_ROBIN_EN: both requesters held high for 4 transactions -> grant order D, IF, D, IF; without the macro -> D, D, D, D.
REQ-030 SHALL cover: mem_ack delayed 5 cycles -> mem_addr, mem_we and mem_wdata stable for all 5 cycles; exactly one done pulse.
REQ-031 SHALL cover: rst asserted in SERVE_D, then mem_ack arrives -> no d_done; state IDLE; all outputs 0.
REQ-032 SHALL cover: d_req dropped mid-SERVE_D with a load returning 0x12345678 -> d_done still pulses; d_rdata=0x12345678.
